fft_8_unloader: RTL

- Consumer end of the 8-point FFT pipeline output interface.
- Captures one parallel frame of eight complex coefficients (x0..x7) and streams them out one per cycle in natural order (k=0..7) over a valid/ready handshake.
- Drives the FFT's stall input so the FFT output registers freeze while this block cannot accept a frame.
- Two-bank ping-pong buffer: one frame drains while the next is captured.

---
 rtl/fft_8_unloader_if.sv | 11 +
 rtl/fft_8_unloader.sv | 54 +++++
 2 files changed

// File: rtl/fft_8_unloader_if.sv
// fft_8_unloader_if: FFT output frame bus (in_valid, x0..x7, scale_en, stall) plus coefficient stream (out_*).
interface fft_8_unloader_if #(parameter int N = 28);
  localparam int W = 2*N+8;
  logic in_valid, scale_en, stall, out_valid, out_last, out_ready;
  logic [W-1:0] x0, x1, x2, x3, x4, x5, x6, x7, out_data;
  logic [2:0] out_index;
  modport master(output in_valid, x0, x1, x2, x3, x4, x5, x6, x7, scale_en, out_ready,
                 input stall, out_data, out_index, out_valid, out_last);
  modport slave(input in_valid, x0, x1, x2, x3, x4, x5, x6, x7, scale_en, out_ready,
                output stall, out_data, out_index, out_valid, out_last);
endinterface

// File: rtl/fft_8_unloader.sv
// fft_8_unloader: ping-pong captures 8-point FFT frames (clk, rst, bus.slave) and streams coefficients k=0..7 over valid/ready.
module fft_8_unloader #(parameter int N = 28) (
  input logic clk,
  input logic rst,
  fft_8_unloader_if.slave bus
);
  localparam int W = 2*N+8;
  localparam int H = N+4;
  logic [W-1:0] bank [2][8];
  logic [W-1:0] xs [8];
  logic [1:0] full;
  logic wr_sel, rd_sel, cap, xfer, done;
  logic [2:0] rd_idx;
  function automatic logic [W-1:0] scale(input logic [W-1:0] x, input logic en);
    logic signed [H-1:0] re, im;
    re = x[W-1:H];
    im = x[H-1:0];
    return en ? {re >>> 3, im >>> 3} : x;
  endfunction
  always_comb begin
    xs[0] = bus.x0;
    xs[1] = bus.x1;
    xs[2] = bus.x2;
    xs[3] = bus.x3;
    xs[4] = bus.x4;
    xs[5] = bus.x5;
    xs[6] = bus.x6;
    xs[7] = bus.x7;
  end
  assign bus.stall = &full;
  assign cap = bus.in_valid & ~bus.stall;
  assign bus.out_valid = full[rd_sel];
  assign xfer = bus.out_valid & bus.out_ready;
  assign done = xfer & (rd_idx == 3'd7);
  assign bus.out_index = rd_idx;
  assign bus.out_last = bus.out_valid & (rd_idx == 3'd7);
  assign bus.out_data = bus.out_valid ? bank[rd_sel][rd_idx] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      rd_idx <= 3'd0;
    end else begin
      if (done) full[rd_sel] <= 1'b0;
      if (cap) full[wr_sel] <= 1'b1;
      wr_sel <= wr_sel ^ cap;
      rd_sel <= rd_sel ^ done;
      if (xfer) rd_idx <= rd_idx + 3'd1;
    end
  end
  always_ff @(posedge clk)
    if (cap) for (int k = 0; k < 8; k++) bank[wr_sel][k] <= scale(xs[k], bus.scale_en);
endmodule
